data_mem_sequencer: RTL and testbench
=====================================

// Module: data_mem_sequencer
// PURPOSE
// - Load/store sequencer between the RV32IM MEM stage and the byte-wide data memory.
// - Splits each LB/LH/LW/LBU/LHU/SB/SH/SW into serial byte accesses, little-endian.
// - Assembles and sign/zero-extends load data; stalls the pipeline via busywait.
// - Is the only master driving the data memory port.
// PARAMETERS
// - ADDR_W  8  memory byte-address width; memory depth = 2**ADDR_W bytes.
// PORTS
// - clock      in   1       system clock, all state updates on posedge
// - reset      in   1       synchronous, active-high
// - mem_read   in   1       pipeline load request, held stable while busywait=1
// - mem_write  in   1       pipeline store request, held stable while busywait=1
// - func3      in   3       RV funct3: [1:0] size (00 B, 01 H, 10/11 W), [2] unsigned (loads only)
// - address    in   32      byte address; only [ADDR_W-1:0] is used
// - writedata  in   32      store data; low 1/2/4 bytes are used
// - readdata   out  32      extended load result, registered
// - busywait   out  1       stall request to the pipeline
// - dm_read    out  1       memory byte read strobe
// - dm_write   out  1       memory byte write strobe
// - dm_addr    out  ADDR_W  memory byte address
// - dm_wdata   out  8       memory write byte
// - dm_rdata   in   8       memory read byte, valid the cycle after dm_read
// BEHAVIOUR
// - Reset (clock edge with reset=1): state=IDLE, readdata=0, counters=0.
//   - dm_read=dm_write=0 and busywait=0 from the next cycle.
//   - Reset wins over any in-flight access; bytes already written stay in memory.
// - States: IDLE, RD, RD_TAIL, WR, DONE. n = 1/2/4 bytes, from func3[1:0].
// - IDLE:
//   - busywait = mem_read XOR mem_write, combinational; this is the only input->output path.
//   - On an edge with exactly one request asserted: latch base, func3, writedata; k=0.
//     Next state is RD for a load, WR for a store.
//   - mem_read=mem_write=1 is illegal: ignored, busywait=0, no memory traffic.
// - RD:
//   - dm_read=1, dm_addr=(base+k) mod 2**ADDR_W.
//   - Byte k-1 is captured from dm_rdata when k>0.
//   - k increments each cycle; after issuing byte n-1, go to RD_TAIL.
// - RD_TAIL: capture byte n-1, then go to DONE.
// - WR:
//   - dm_write=1, dm_addr=(base+k) mod 2**ADDR_W, dm_wdata=writedata[8k+7:8k].
//   - k increments; after byte n-1, go to DONE.
// - DONE:
//   - busywait=0 for exactly one cycle, then IDLE unconditionally (no retrigger on a held request).
//   - For loads, readdata is updated on the edge entering DONE and holds until the next load completes.
// - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; W ignores func3[2].
// - Busy cycles, request cycle included: LB 3, LH 4, LW 6, SB 2, SH 3, SW 5.
//   The pipeline resumes on the edge ending DONE.
// - Address wrap: byte addresses wrap modulo 2**ADDR_W (e.g. LW at 0xFE reads FE,FF,00,01).
// - No misalignment trap; unaligned accesses are legal byte sequences.
// - dm_* outputs are decoded from registered state only; dm_read and dm_write are never both 1.
// - In IDLE and DONE, dm_read=dm_write=0 (dm_addr and dm_wdata are don't-care).
// STRUCTURE
// - Package mem_ctrl_pkg holds:
//   - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101);
//   - the state encoding (IDLE..DONE);
//   - the size-decode function (func3 -> byte count).
// - Sub-module load_extend: combinational; assembles up to 4 bytes and size/sign-extends to 32 bits.
// - FSM, byte counter, request latches and the dm_* decode live in the top module.
// TESTING
// - Reset: hold reset 2 cycles mid-LW
//   -> next cycle busywait=0, dm_read=0, readdata=0, state IDLE.
// - SW 0xDEADBEEF @0x10, then LW @0x10
//   -> mem[10..13]=EF,BE,AD,DE; readdata=0xDEADBEEF; busy 5 and 6 cycles.
// - SB 0x80 @0x20, then LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080.
// - SH 0x8001 @0x31 (unaligned), then LH @0x31 -> 0xFFFF8001; LHU -> 0x00008001.
// - LW @0xFE with mem FE..01 = 11,22,33,44
//   -> dm_addr sequence FE,FF,00,01; readdata=0x44332211.
// - mem_read=mem_write=1 for 3 cycles -> busywait=0, no dm strobes, readdata unchanged.
// - Back-to-back: a new request asserted in the cycle after DONE
//   -> accepted from IDLE with correct busy count and no lost or duplicated access.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory load/store sequencer: funct3 codes,
// FSM state encoding and access-size decode.
package mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_TAIL = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Byte count of an access; both 10 and 11 encodings are full words.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: takes up to four little-endian bytes and
// size/sign-extends them to a 32-bit register value.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [3:0][7:0] bytes_in,
  input  logic [2:0]      func3,
  output logic [31:0]     data_out
);

  logic sx;

  always_comb begin
    sx       = 1'b0;
    data_out = bytes_in;
    case (func3)
      F3_B:  begin sx = bytes_in[0][7]; data_out = {{24{sx}}, bytes_in[0]}; end
      F3_BU: data_out = {24'h0, bytes_in[0]};
      F3_H:  begin sx = bytes_in[1][7]; data_out = {{16{sx}}, bytes_in[1], bytes_in[0]}; end
      F3_HU: data_out = {16'h0, bytes_in[1], bytes_in[0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_sequencer.sv
// Serialises RV32 loads/stores into byte accesses on a byte-wide data memory,
// stalling the pipeline with busywait until the access completes.
module data_mem_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [31:0]       address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              busywait,
  output logic              dm_read,
  output logic              dm_write,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_wdata,
  input  logic [7:0]        dm_rdata
);

  state_t          state, state_nxt;
  logic [2:0]      k, n;
  logic [ADDR_W-1:0] base;
  logic [2:0]      f3_q;
  logic [31:0]     wdata_q;
  logic [3:0][7:0] rbuf, rbuf_nxt;
  logic [31:0]     ext_data;
  logic            req_ok, last, cap_en;
  logic [1:0]      cap_idx;
  logic            unused_addr;

  assign unused_addr = ^address[31:ADDR_W];

  assign req_ok  = mem_read ^ mem_write;
  assign n       = size_bytes(f3_q);
  assign last    = (k == n - 3'd1);
  // Memory answers one cycle late, so the byte arriving now belongs to k-1.
  assign cap_en  = ((state == RD) && (k != 3'd0)) || (state == RD_TAIL);
  assign cap_idx = k[1:0] - 2'd1;

  always_comb begin
    rbuf_nxt = rbuf;
    if (cap_en) rbuf_nxt[cap_idx] = dm_rdata;
  end

  load_extend u_ext (
    .bytes_in (rbuf_nxt),
    .func3    (f3_q),
    .data_out (ext_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      base     <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      rbuf     <= '0;
      readdata <= '0;
    end else begin
      state <= state_nxt;
      rbuf  <= rbuf_nxt;
      case (state)
        IDLE: if (req_ok) begin
          base    <= address[ADDR_W-1:0];
          f3_q    <= func3;
          wdata_q <= writedata;
          k       <= '0;
        end
        RD, WR:  k <= k + 3'd1;
        RD_TAIL: readdata <= ext_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busywait  = 1'b0;
    case (state)
      IDLE: begin
        busywait = req_ok;
        if (req_ok) state_nxt = mem_read ? RD : WR;
      end
      RD: begin
        busywait = 1'b1;
        if (last) state_nxt = RD_TAIL;
      end
      RD_TAIL: begin
        busywait  = 1'b1;
        state_nxt = DONE;
      end
      WR: begin
        busywait = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dm_read  = (state == RD);
  assign dm_write = (state == WR);
  assign dm_addr  = base + ADDR_W'(k[1:0]);
  assign dm_wdata = wdata_q[{k[1:0], 3'b000} +: 8];

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Self-checking bench: byte memory model, shadow reference memory and a
// scoreboard of expected load data / busy counts.
module tb_data_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] address = 32'd0, writedata = 32'd0;
  logic [31:0] readdata;
  logic        busywait, dm_read, dm_write;
  logic [7:0]  dm_addr, dm_wdata;
  logic [7:0]  dm_rdata = 8'h00;

  data_mem_sequencer #(.ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clock = ~clock;

  logic [7:0] mem    [256] = '{default: 8'h00};
  logic [7:0] shadow [256] = '{default: 8'h00};
  logic [7:0] rd_addrs [$];
  int strobes = 0, both = 0;

  always @(posedge clock) begin
    if (dm_read) begin
      dm_rdata <= mem[dm_addr];
      rd_addrs.push_back(dm_addr);
    end
    if (dm_write) mem[dm_addr] <= dm_wdata;
    if (dm_read || dm_write) strobes <= strobes + 1;
    if (dm_read && dm_write) both <= both + 1;
  end

  typedef struct { logic [31:0] data; int busy; } exp_t;
  exp_t sb [$];
  int n_tests = 0, n_fail = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  ai;
    w = 32'd0;
    for (int i = 0; i < nbytes(f3); i++) begin
      ai = a + 8'(i);
      w[8*i +: 8] = shadow[ai];
    end
    if (f3 == 3'b000 && w[7])  w[31:8]  = 24'hFFFFFF;
    if (f3 == 3'b001 && w[15]) w[31:16] = 16'hFFFF;
    return w;
  endfunction

  // Drives one request and leaves it held through DONE, so the next call
  // asserts its request in the cycle right after DONE (back-to-back).
  task automatic run(input logic rd, input logic [2:0] f3, input logic [7:0] a,
                     input logic [31:0] wd, input string tag);
    exp_t e;
    int busy;
    logic [7:0] ai;
    if (!rd)
      for (int i = 0; i < nbytes(f3); i++) begin
        ai = a + 8'(i);
        shadow[ai] = wd[8*i +: 8];
      end
    e.data = rd ? ref_load(a, f3) : last_rd;
    e.busy = nbytes(f3) + (rd ? 2 : 1);
    sb.push_back(e);
    @(negedge clock);
    mem_read = rd; mem_write = !rd; func3 = f3; address = {24'h0, a}; writedata = wd;
    #1;
    busy = 0;
    while (busywait && busy < 20) begin
      busy++;
      @(negedge clock);
      #1;
    end
    e = sb.pop_front();
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".data"}, readdata, e.data);
    if (rd) last_rd = e.data;
  endtask

  task automatic idle();
    @(negedge clock);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int s0;
    logic [7:0] ra;
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] rf;

    repeat (2) @(negedge clock);
    chk("rst.readdata", readdata, 32'd0);
    chk("rst.busy", {31'd0, busywait}, 32'd0);
    chk("rst.strobes", {30'd0, dm_read, dm_write}, 32'd0);
    reset = 1'b0;

    run(1'b0, 3'b010, 8'h10, 32'hDEADBEEF, "sw10");
    idle();
    chk("mem10", {24'h0, mem[8'h10]}, 32'hEF);
    chk("mem11", {24'h0, mem[8'h11]}, 32'hBE);
    chk("mem12", {24'h0, mem[8'h12]}, 32'hAD);
    chk("mem13", {24'h0, mem[8'h13]}, 32'hDE);
    run(1'b1, 3'b010, 8'h10, 32'h0, "lw10");
    chk("lw10.const", readdata, 32'hDEADBEEF);

    run(1'b0, 3'b000, 8'h20, 32'h00000080, "sb20");
    run(1'b1, 3'b000, 8'h20, 32'h0, "lb20");
    chk("lb20.const", readdata, 32'hFFFFFF80);
    run(1'b1, 3'b100, 8'h20, 32'h0, "lbu20");
    chk("lbu20.const", readdata, 32'h00000080);

    run(1'b0, 3'b001, 8'h31, 32'h00008001, "sh31");
    run(1'b1, 3'b001, 8'h31, 32'h0, "lh31");
    chk("lh31.const", readdata, 32'hFFFF8001);
    run(1'b1, 3'b101, 8'h31, 32'h0, "lhu31");
    chk("lhu31.const", readdata, 32'h00008001);

    run(1'b0, 3'b010, 8'hFE, 32'h44332211, "swfe");
    rd_addrs.delete();
    run(1'b1, 3'b010, 8'hFE, 32'h0, "lwfe");
    chk("lwfe.const", readdata, 32'h44332211);
    chk("lwfe.naddr", 32'(rd_addrs.size()), 32'd4);
    if (rd_addrs.size() == 4) begin
      chk("lwfe.a0", {24'h0, rd_addrs[0]}, 32'hFE);
      chk("lwfe.a1", {24'h0, rd_addrs[1]}, 32'hFF);
      chk("lwfe.a2", {24'h0, rd_addrs[2]}, 32'h00);
      chk("lwfe.a3", {24'h0, rd_addrs[3]}, 32'h01);
    end

    // Illegal simultaneous read+write is ignored.
    idle();
    s0 = strobes;
    @(negedge clock);
    mem_read = 1'b1; mem_write = 1'b1; address = 32'h10; func3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("both.busy", {31'd0, busywait}, 32'd0);
      @(negedge clock);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    chk("both.strobes", 32'(strobes), 32'(s0));
    chk("both.readdata", readdata, last_rd);

    for (int i = 0; i < 24; i++) begin
      ra = 8'h40 + 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        rf = f3s[$urandom_range(0, 4)];
        run(1'b1, rf, ra, 32'h0, "rnd.ld");
      end else begin
        rf = f3s[$urandom_range(0, 2)];
        run(1'b0, rf, ra, $urandom, "rnd.st");
      end
    end
    chk("never.both", 32'(both), 32'd0);

    // Reset in the middle of a word load.
    idle();
    @(negedge clock);
    mem_read = 1'b1; func3 = 3'b010; address = 32'h10;
    repeat (2) @(negedge clock);
    reset = 1'b1; mem_read = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rstmid.busy", {31'd0, busywait}, 32'd0);
    chk("rstmid.rd", {31'd0, dm_read}, 32'd0);
    chk("rstmid.readdata", readdata, 32'd0);
    @(negedge clock);
    chk("rstmid.rd2", {31'd0, dm_read}, 32'd0);
    last_rd = 32'd0;
    run(1'b1, 3'b010, 8'h10, 32'h0, "lw.after");
    chk("lw.after.const", readdata, 32'hDEADBEEF);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
